actor_motion_ctrl: RTL and testbench

//  Grid-aware motion controller for one maze actor (Pacman or ghost), generalising the single-sprite ball mover.
//  Per frame_tick: buffers a requested turn, checks walls through a req/ack probe port (shared wall-map arbiter),

---
 rtl/actor_motion_ctrl_if.sv | 21 ++
 rtl/actor_motion_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_actor_motion_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/actor_motion_ctrl_if.sv
// Wall-map probe channel between an actor controller (master) and the shared wall-map arbiter (slave).
// The controller holds req/x/y steady until it samples ack; wall is qualified by ack.
interface actor_motion_ctrl_if #(
  parameter int COORD_W = 10
);
  logic               probe_req;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;
  logic               probe_ack;
  logic               probe_wall;

  modport master (
    output probe_req, probe_x, probe_y,
    input  probe_ack, probe_wall
  );

  modport slave (
    input  probe_req, probe_x, probe_y,
    output probe_ack, probe_wall
  );
endinterface

// File: rtl/actor_motion_ctrl.sv
// Per-frame maze actor mover: buffered turn, wall probes over req/ack, then one step (pos moves 3/5 cycles after tick).
// Probes wait indefinitely for ack; ticks arriving while busy are dropped and flagged. Define WRAP_TUNNEL_EN for horizontal wrap.
module actor_motion_ctrl #(
  parameter int COORD_W   = 10,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 350,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int SIZE      = 16,
  parameter int STEP      = 1,
  parameter int GRID      = 8,
  parameter int TURN_HOLD = 32
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_tick,
  input  logic [7:0]          keycode,
  actor_motion_ctrl_if.master probe,
  output logic [COORD_W-1:0]  pos_x,
  output logic [COORD_W-1:0]  pos_y,
  output logic [1:0]          dir,
  output logic                moving,
  output logic                busy,
  output logic                overrun
);
  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_U = 2'b11;
  localparam int OFF    = SIZE + STEP;
  localparam int HOLD_W = $clog2(TURN_HOLD + 1);

  typedef enum logic [1:0] {IDLE, PROBE_TURN, PROBE_FWD, UPDATE} state_t;
  state_t state, state_nx;

  logic               key_vld;
  logic [1:0]         key_dir;
  logic               qvalid;
  logic [1:0]         qdir;
  logic [1:0]         tdir;
  logic [1:0]         pdir;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  hold_eff;
  logic               q_vld_eff;
  logic [1:0]         qdir_eff;
  logic               aligned;
  logic               turn_ok;
  logic               tick_take;
  logic               probe_done;
  logic               turn_clear;
  logic               go;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;

  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_L;
    case (keycode)
      8'h04:   key_dir = DIR_L;
      8'h07:   key_dir = DIR_R;
      8'h16:   key_dir = DIR_D;
      8'h1A:   key_dir = DIR_U;
      default: key_vld = 1'b0;
    endcase
  end

  // A key arriving with the tick is taken first, so the tick sees the fresh request.
  assign q_vld_eff  = key_vld | qvalid;
  assign qdir_eff   = key_vld ? key_dir : qdir;
  assign hold_eff   = key_vld ? HOLD_W'(TURN_HOLD) : hold;
  assign aligned    = qdir_eff[1] ? ((pos_x % COORD_W'(GRID)) == '0)
                                  : ((pos_y % COORD_W'(GRID)) == '0);
  assign turn_ok    = q_vld_eff && (!moving || (qdir_eff == {dir[1], ~dir[0]}) || aligned);
  assign tick_take  = frame_tick && (state == IDLE);
  assign probe_done = probe.probe_req && probe.probe_ack;
  assign turn_clear = probe_done && (state == PROBE_TURN) && !probe.probe_wall;
  assign busy       = (state != IDLE);
  assign pdir       = (state == PROBE_TURN) ? tdir : dir;

  always_comb begin
    pt_x = pos_x;
    pt_y = pos_y;
    case (pdir)
      DIR_L:   pt_x = (int'(pos_x) < OFF) ? '0 : pos_x - COORD_W'(OFF);
      DIR_R:   pt_x = pos_x + COORD_W'(OFF);
      DIR_D:   pt_y = pos_y + COORD_W'(OFF);
      default: pt_y = (int'(pos_y) < OFF) ? '0 : pos_y - COORD_W'(OFF);
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          if (turn_ok)     state_nx = PROBE_TURN;
          else if (moving) state_nx = PROBE_FWD;
        end
      end
      PROBE_TURN: if (probe_done) state_nx = (probe.probe_wall && moving) ? PROBE_FWD : UPDATE;
      PROBE_FWD:  if (probe_done) state_nx = UPDATE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      probe.probe_req <= 1'b0;
      probe.probe_x   <= '0;
      probe.probe_y   <= '0;
    end else if (probe_done) begin
      probe.probe_req <= 1'b0;
    end else if ((state == PROBE_TURN || state == PROBE_FWD) && !probe.probe_req) begin
      probe.probe_req <= 1'b1;
      probe.probe_x   <= pt_x;
      probe.probe_y   <= pt_y;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      qvalid  <= 1'b0;
      qdir    <= DIR_L;
      hold    <= '0;
      tdir    <= DIR_L;
      dir     <= DIR_L;
      go      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (turn_clear) begin
        dir    <= tdir;
        qvalid <= 1'b0;
      end
      if (key_vld) begin
        qdir   <= key_dir;
        qvalid <= 1'b1;
        hold   <= HOLD_W'(TURN_HOLD);
      end
      if (tick_take) begin
        tdir <= qdir_eff;
        if (hold_eff != '0) begin
          hold <= hold_eff - HOLD_W'(1);
          if (hold_eff == HOLD_W'(1)) qvalid <= 1'b0;
        end
      end
      if (probe_done)         go      <= !probe.probe_wall;
      if (frame_tick && busy) overrun <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x  <= COORD_W'(X_CENTER);
      pos_y  <= COORD_W'(Y_CENTER);
      moving <= 1'b0;
    end else if (state == UPDATE) begin
      moving <= go;
      if (go) begin
        case (dir)
          DIR_L: begin
            if (int'(pos_x) < X_MIN + SIZE + STEP) begin
`ifdef WRAP_TUNNEL_EN
              pos_x  <= COORD_W'(X_MAX - SIZE);
`else
              pos_x  <= COORD_W'(X_MIN + SIZE);
              moving <= 1'b0;
`endif
            end else begin
              pos_x <= pos_x - COORD_W'(STEP);
            end
          end
          DIR_R: begin
            if (int'(pos_x) + STEP > X_MAX - SIZE) begin
`ifdef WRAP_TUNNEL_EN
              pos_x  <= COORD_W'(X_MIN + SIZE);
`else
              pos_x  <= COORD_W'(X_MAX - SIZE);
              moving <= 1'b0;
`endif
            end else begin
              pos_x <= pos_x + COORD_W'(STEP);
            end
          end
          DIR_D: begin
            if (int'(pos_y) + STEP > Y_MAX - SIZE) begin
              pos_y  <= COORD_W'(Y_MAX - SIZE);
              moving <= 1'b0;
            end else begin
              pos_y <= pos_y + COORD_W'(STEP);
            end
          end
          default: begin
            if (int'(pos_y) < Y_MIN + SIZE + STEP) begin
              pos_y  <= COORD_W'(Y_MIN + SIZE);
              moving <= 1'b0;
            end else begin
              pos_y <= pos_y - COORD_W'(STEP);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_actor_motion_ctrl.sv
// Scoreboard bench for actor_motion_ctrl: stimulus pushes expected probe points and step results,
// a monitor pops them as the DUT answers probes and returns to idle.
module tb_actor_motion_ctrl;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, busy, overrun;

  always #5 Clk = ~Clk;

  actor_motion_ctrl_if #(.COORD_W(10)) pif();

  actor_motion_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .probe(pif), .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .moving(moving), .busy(busy), .overrun(overrun)
  );

  typedef struct packed { logic [9:0] x; logic [9:0] y; } pt_t;
  typedef struct packed { logic [9:0] x; logic [9:0] y; logic [1:0] d; logic m; } upd_t;
  pt_t  exp_probe[$];
  upd_t exp_upd[$];

  int n_chk = 0, n_fail = 0;
  int probe_cnt = 0, upd_cnt = 0;
  int ack_delay = 0;
  logic wall_val = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_step(input int px, input int py, input int ux, input int uy,
                             input logic [1:0] d, input logic m);
    exp_probe.push_back('{x: 10'(px), y: 10'(py)});
    exp_upd.push_back('{x: 10'(ux), y: 10'(uy), d: d, m: m});
  endtask

  // Wall-map responder: acks each request after ack_delay cycles, checking the request holds still.
  initial begin
    logic [9:0] hx, hy;
    pif.probe_ack  = 1'b0;
    pif.probe_wall = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (Reset_n && pif.probe_req) begin
        hx = pif.probe_x;
        hy = pif.probe_y;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge Clk); #1;
          if (!Reset_n) break;
          chk("req_held", pif.probe_req, 1);
          chk("probe_x_held", pif.probe_x, hx);
          chk("probe_y_held", pif.probe_y, hy);
        end
        if (Reset_n) begin
          pif.probe_ack  = 1'b1;
          pif.probe_wall = wall_val;
          @(posedge Clk); #1;
          pif.probe_ack  = 1'b0;
          pif.probe_wall = 1'b0;
        end
      end
    end
  end

  initial begin
    logic busy_d;
    pt_t  ep;
    upd_t eu;
    busy_d = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        busy_d = 1'b0;
      end else begin
        if (pif.probe_req && pif.probe_ack) begin
          probe_cnt++;
          if (exp_probe.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_probe: got (%0d,%0d), expected none", pif.probe_x, pif.probe_y);
          end else begin
            ep = exp_probe.pop_front();
            chk("probe_x", pif.probe_x, ep.x);
            chk("probe_y", pif.probe_y, ep.y);
          end
        end
        if (busy_d && !busy) begin
          upd_cnt++;
          if (exp_upd.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_update: got pos (%0d,%0d), expected none", pos_x, pos_y);
          end else begin
            eu = exp_upd.pop_front();
            chk("upd_pos_x", pos_x, eu.x);
            chk("upd_pos_y", pos_y, eu.y);
            chk("upd_dir", dir, eu.d);
            chk("upd_moving", moving, eu.m);
          end
        end
        busy_d = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_tick();
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
  endtask

  task automatic key_pulse(input logic [7:0] k);
    @(posedge Clk); #1 keycode = k;
    @(posedge Clk); #1 keycode = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy 1 after %0d cycles, expected 0", n);
    end
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic tick_wait();
    pulse_tick();
    wait_idle();
  endtask

  initial begin
    int pc, uc;
    Reset_n = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_pos_x", pos_x, 320);
    chk("rst_pos_y", pos_y, 350);
    chk("rst_dir", dir, 0);
    chk("rst_moving", moving, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_probe_req", pif.probe_req, 0);
    chk("rst_probe_x", pif.probe_x, 0);
    chk("rst_probe_y", pif.probe_y, 0);
    Reset_n = 1'b1;

    // Reset while a probe is outstanding, after an overrun has been flagged.
    ack_delay = 20;
    key_pulse(8'h07);
    pulse_tick();
    @(posedge Clk); #1;
    chk("midprobe_req_up", pif.probe_req, 1);
    pulse_tick();
    #2;
    chk("midprobe_overrun", overrun, 1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_probe_req", pif.probe_req, 0);
    chk("midrst_pos_x", pos_x, 320);
    chk("midrst_pos_y", pos_y, 350);
    chk("midrst_dir", dir, 0);
    chk("midrst_moving", moving, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    ack_delay = 0;
    repeat (2) @(posedge Clk);

    // First turn from rest: one probe, position moves three cycles after the tick.
    key_pulse(8'h07);
    expect_step(337, 350, 321, 350, 2'b01, 1'b1);
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_req_not_yet", pif.probe_req, 0);
    @(posedge Clk); #1;
    chk("lat_req_rise", pif.probe_req, 1);
    @(posedge Clk); #1;
    chk("lat_pos_hold", pos_x, 320);
    @(posedge Clk); #1;
    chk("lat_pos_step", pos_x, 321);
    wait_idle();

    // Forward step, then blocked, then a tick that must not probe.
    expect_step(338, 350, 322, 350, 2'b01, 1'b1);
    tick_wait();
    wall_val = 1'b1;
    expect_step(339, 350, 322, 350, 2'b01, 1'b0);
    tick_wait();
    pc = probe_cnt;
    tick_wait();
    chk("stopped_no_probe", probe_cnt, pc);
    chk("stopped_moving", moving, 0);
    chk("stopped_dir", dir, 1);

    // Restart right, then request up; turn waits for x aligned to the grid.
    wall_val = 1'b0;
    key_pulse(8'h07);
    expect_step(339, 350, 323, 350, 2'b01, 1'b1);
    tick_wait();
    key_pulse(8'h1A);
    for (int x = 323; x < 328; x++) begin
      expect_step(x + 17, 350, x + 1, 350, 2'b01, 1'b1);
      tick_wait();
    end
    expect_step(328, 333, 328, 349, 2'b11, 1'b1);
    tick_wait();

    // Blocked going up; a blocked left request is retried for 32 ticks, then expires.
    wall_val = 1'b1;
    expect_step(328, 332, 328, 349, 2'b11, 1'b0);
    tick_wait();
    key_pulse(8'h04);
    for (int i = 0; i < 32; i++) begin
      expect_step(311, 349, 328, 349, 2'b11, 1'b0);
      tick_wait();
    end
    pc = probe_cnt;
    tick_wait();
    chk("turn_expired_no_probe", probe_cnt, pc);
    chk("turn_expired_dir", dir, 3);

    // Slow ack with an extra tick while busy: one step, overrun sticks.
    wall_val = 1'b0;
    chk("overrun_clear_before", overrun, 0);
    ack_delay = 4;
    key_pulse(8'h07);
    expect_step(345, 349, 329, 349, 2'b01, 1'b1);
    uc = upd_cnt;
    pulse_tick();
    @(posedge Clk);
    pulse_tick();
    wait_idle();
    repeat (4) @(posedge Clk);
    #1;
    chk("overrun_sticky", overrun, 1);
    chk("one_step_only", upd_cnt, uc + 1);
    chk("slow_ack_pos_x", pos_x, 329);
    ack_delay = 0;

    // Key and tick in the same cycle reverse to the left; run to the left bound.
    expect_step(312, 349, 328, 349, 2'b00, 1'b1);
    @(posedge Clk); #1 keycode = 8'h04; frame_tick = 1'b1;
    @(posedge Clk); #1 keycode = 8'h00; frame_tick = 1'b0;
    wait_idle();
    for (int x = 328; x > 17; x--) begin
      expect_step(x - 17, 349, x - 1, 349, 2'b00, 1'b1);
      tick_wait();
    end
    expect_step(0, 349, 16, 349, 2'b00, 1'b1);
    tick_wait();
`ifdef WRAP_TUNNEL_EN
    expect_step(0, 349, 623, 349, 2'b00, 1'b1);
    tick_wait();
    expect_step(606, 349, 622, 349, 2'b00, 1'b1);
    tick_wait();
`else
    expect_step(0, 349, 16, 349, 2'b00, 1'b0);
    tick_wait();
    pc = probe_cnt;
    tick_wait();
    chk("clamped_no_probe", probe_cnt, pc);
    chk("clamped_pos_x", pos_x, 16);
`endif

    repeat (5) @(posedge Clk);
    chk("probe_queue_drained", exp_probe.size(), 0);
    chk("update_queue_drained", exp_upd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
